// File: rtl/priority_encoder_hs.sv
// Registered 4-to-2 priority encoder with a valid/ack output handshake.
// Captures once per request burst and counts acknowledged transfers.
module priority_encoder_hs #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d0,
  input  logic             d1,
  input  logic             d2,
  input  logic             d3,
  input  logic             ack,
  output logic             s0,
  output logic             s1,
  output logic             valid,
  output logic             multi,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RELEASE
  } state_t;

  state_t           state_q;
  logic [1:0]       code_q;
  logic             valid_q;
  logic             multi_q;
  logic [CNT_W-1:0] count_q;

  logic [3:0] req;
  logic       any_req;
  logic [1:0] code_d;
  logic       multi_d;

  assign req     = {d3, d2, d1, d0};
  assign any_req = |req;
  // Clearing the lowest set bit leaves something only if 2+ bits were set.
  assign multi_d = |(req & (req - 4'd1));

  always_comb begin
    code_d = 2'b00;
    priority case (1'b1)
      d3:      code_d = 2'b11;
      d2:      code_d = 2'b10;
      d1:      code_d = 2'b01;
      default: code_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= 2'b00;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            code_q  <= code_d;
            multi_q <= multi_d;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (ack) begin
            valid_q <= 1'b0;
            count_q <= count_q + CNT_W'(1);
            state_q <= any_req ? RELEASE : IDLE;
          end
        end
        RELEASE: begin
          if (!any_req) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s0    = code_q[0];
  assign s1    = code_q[1];
  assign valid = valid_q;
  assign multi = multi_q;
  assign count = count_q;

endmodule

// File: tb/tb_priority_encoder_hs.sv
// Bench for priority_encoder_hs: directed test-plan sequences plus
// random traffic, checked against a transfer-level reference model.
module tb_priority_encoder_hs;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] d   = 4'b0;
  logic       ack = 1'b0;
  logic       s0, s1, valid, multi;
  logic [7:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one pending code, and a flag for "must see all-zero".
  logic       m_valid;
  logic       m_wait_zero;
  int         m_code;
  logic       m_multi;
  int         m_count;

  priority_encoder_hs #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .d0    (d[0]),
    .d1    (d[1]),
    .d2    (d[2]),
    .d3    (d[3]),
    .ack   (ack),
    .s0    (s0),
    .s1    (s1),
    .valid (valid),
    .multi (multi),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid     = 1'b0;
    m_wait_zero = 1'b0;
    m_code      = 0;
    m_multi     = 1'b0;
    m_count     = 0;
  endtask

  task automatic model_edge();
    int ones;
    ones = $countones(d);
    if (m_valid) begin
      if (ack) begin
        m_valid     = 1'b0;
        m_count     = (m_count + 1) % 256;
        m_wait_zero = (ones != 0);
      end
    end else if (m_wait_zero) begin
      if (ones == 0) m_wait_zero = 1'b0;
    end else if (ones != 0) begin
      for (int i = 0; i < 4; i++)
        if (d[i]) m_code = i;
      m_multi = (ones >= 2);
      m_valid = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, int'(valid), int'(m_valid));
    chk({tag, ".code"}, int'({s1, s0}), m_code);
    chk({tag, ".multi"}, int'(multi), int'(m_multi));
    chk({tag, ".count"}, int'(count), m_count);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic quiet_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
    d   = 4'b0;
    ack = 1'b0;
  endtask

  initial begin
    model_reset();
    async_reset("rst");
    step("rst_idle");

    for (int i = 0; i < 4; i++) begin
      d = 4'(1 << i);
      step("sweep_cap");
      chk("sweep_code", int'({s1, s0}), i);
      chk("sweep_multi", int'(multi), 0);
      ack = 1'b1;
      step("sweep_ack");
      ack = 1'b0;
      d   = 4'b0;
      step("sweep_drop");
    end
    chk("sweep_count", int'(count), 4);

    d = 4'b1010;
    step("mh13");
    chk("mh13_code", int'({s1, s0}), 3);
    chk("mh13_multi", int'(multi), 1);
    ack = 1'b1;
    d   = 4'b0;
    step("mh13_ack");
    ack = 1'b0;
    d   = 4'b0101;
    step("mh02");
    chk("mh02_code", int'({s1, s0}), 2);
    chk("mh02_multi", int'(multi), 1);
    ack = 1'b1;
    d   = 4'b0;
    step("mh02_ack");
    ack = 1'b0;

    d = 4'b0100;
    step("hold_cap");
    ack = 1'b1;
    step("hold_ack");
    ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("hold_rel");
      chk("hold_novalid", int'(valid), 0);
    end
    chk("hold_count", int'(count), 7);
    d = 4'b0;
    step("hold_drop");
    d = 4'b0010;
    step("rearm");
    chk("rearm_code", int'({s1, s0}), 1);
    chk("rearm_valid", int'(valid), 1);
    ack = 1'b1;
    d   = 4'b0;
    step("rearm_ack");
    ack = 1'b0;

    d = 4'b0001;
    step("chg_cap");
    d = 4'b1000;
    step("chg_hold");
    step("chg_hold2");
    chk("chg_code", int'({s1, s0}), 0);
    ack = 1'b1;
    step("chg_ack");
    ack = 1'b0;
    d   = 4'b0;
    step("chg_drop");

    for (int i = 0; i < 600; i++) begin
      d   = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom);
      ack = 1'($urandom);
      step("rnd");
    end
    ack = 1'b0;
    d   = 4'b0;

    async_reset("rst2");
    for (int i = 0; i < 256; i++) begin
      d = 4'($urandom_range(1, 15));
      quiet_step();
      ack = 1'b1;
      d   = 4'b0;
      quiet_step();
      ack = 1'b0;
    end
    step("wrap_end");
    chk("wrap_count", int'(count), 0);

    d = 4'b1000;
    step("mid_cap");
    chk("mid_valid", int'(valid), 1);
    async_reset("mid_rst");
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_count", int'(count), 0);
    d = 4'b0100;
    step("post_rst");
    chk("post_rst_code", int'({s1, s0}), 2);
    chk("post_rst_valid", int'(valid), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_encoder_hs.md
# priority_encoder_hs

Registered 4-to-2 priority encoder with a valid/ack output handshake. It is the inverse end of the 2-to-4 active-high decoder path. It watches four active-high request lines `d0`..`d3` and captures the highest-priority active line as a 2-bit code `s1`,`s0`. It holds that code until the consumer acknowledges, then waits for all requests to drop before re-arming. It also flags multi-hot captures and counts completed transfers, so decoder/encoder loopback benches can check round-trips.

## Interface
- `CNT_W`, default 8 — width of the transfer counter.

- `clk`  input  1  — system clock, rising-edge active.
- `rst`  input  1  — asynchronous, active-high reset.
- `d0`  input  1  — request line 0, active high, lowest priority.
- `d1`  input  1  — request line 1.
- `d2`  input  1  — request line 2.
- `d3`  input  1  — request line 3, highest priority.
- `ack`  input  1  — consumer accepts the presented code; only meaningful while `valid`=1.
- `s0`  output  1  — encoded code, LSB.
- `s1`  output  1  — encoded code, MSB.
- `valid`  output  1  — code on `s1`,`s0` is held and awaiting `ack`.
- `multi`  output  1  — more than one `d` line was high at capture; qualified by `valid`.
- `count`  output  `CNT_W`  — number of acknowledged transfers, modulo 2^`CNT_W`.

## Operation
- Single clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset state: `s1`=0, `s0`=0, `valid`=0, `multi`=0, `count`=0, FSM=IDLE. Reset asserted mid-transfer aborts it immediately: the code is lost and `count` is not incremented.
- FSM states:
  - IDLE: if any `d` line is high at a rising edge, capture the code, set `valid`=1, go to HOLD. Otherwise stay in IDLE.
  - HOLD: `s1`,`s0`,`multi` are frozen and `d` changes are ignored. If `ack`=1 at an edge: clear `valid`, increment `count`, go to RELEASE. If all `d` lines are also 0 at that same edge, go directly to IDLE instead.
  - RELEASE: `valid`=0 and new requests are ignored. Go to IDLE at the first edge where all `d` lines are 0.
- Priority encoding: `d3`→11, `d2`→10, `d1`→01, `d0`→00; a higher line masks all lower ones.
- `multi`=1 when two or more `d` lines are high at the capture edge. It is written at every capture.
- `s1`,`s0`,`multi` keep their last captured value after `ack`; only `valid` indicates freshness.
- `ack` is ignored in IDLE and RELEASE.
- `count` wraps from all-ones to 0 without a flag.
- A request held continuously produces exactly one transfer. A new transfer requires all `d` lines to return to 0 first.

## Timing
- Capture latency: `d` lines stable before edge N → `valid`, `s1`, `s0`, `multi` are updated after edge N (one registered stage, no combinational path from input to output).
- `valid` rises at edge N and stays high for at least one full cycle.
- With `ack` high at edge N+k (k≥1): `valid` falls and `count` increments after that same edge.
- Minimum transfer period is 3 edges: capture, ack, release. It drops to 2 edges if the `d` lines are already 0 when `ack` is taken.
- `ack` held high continuously: accepted at the first edge after `valid` rises, giving a 1-cycle `valid` pulse.
- Inputs are treated as synchronous to `clk`; there is no internal synchroniser.

## Test plan
- Reset: assert `rst` asynchronously between clock edges → all outputs 0 immediately, before the next clock edge; release `rst` → still IDLE with `valid`=0.
- Single-hot sweep: drive `d0`, then `d1`, `d2`, `d3`, each until acked and then dropped → codes 00, 01, 10, 11; `multi`=0 every time; `count`=4.
- Multi-hot: drive `d1`=1 and `d3`=1 → `s1`,`s0`=11, `multi`=1. Drive `d0`+`d2` → 10, `multi`=1.
- Hold/re-arm: keep `d2`=1 through `ack` and for 5 further cycles → exactly one `valid` pulse, FSM stays in RELEASE, `count`+1 only. Drop `d2` then raise `d1` → new capture of 01.
- Input change during HOLD: capture `d0` (code 00), then switch to `d3` before `ack` → code stays 00 until acked.
- Wrap and reset mid-operation: 256 acked transfers with `CNT_W`=8 → `count` returns to 0. Assert `rst` while `valid`=1 → `valid`=0, `count`=0, and the next request is captured normally after reset is released.
